// File: rtl/ram2_ctrl.sv
// Ram2 SRAM controller: arbitrates instruction fetch and data ports onto one async SRAM.
// Optional one-entry fetch buffer compiled in with `RAM2_FETCH_BUF_EN.
module ram2_ctrl #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              busy,
    output logic              Ram2_EN,
    output logic              Ram2_OE,
    output logic              Ram2_WE,
    output logic [ADDR_W-1:0] Ram2_address,
    inout  wire  [DATA_W-1:0] Ram2_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_SAMPLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t            state, state_next;
    logic              gnt_mem;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant_mem, grant_if;
    logic              buf_hit;
    logic              bus_drive;

`ifdef RAM2_FETCH_BUF_EN
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              buf_valid;

    assign buf_hit = buf_valid && (if_addr == buf_addr);

    // Buffer fills on every completed SRAM fetch; a data write to the same word invalidates it.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            buf_addr  <= '0;
            buf_data  <= '0;
            buf_valid <= 1'b0;
        end else begin
            if (state == RD_SAMPLE && !gnt_mem) begin
                buf_addr  <= addr_q;
                buf_data  <= Ram2_data;
                buf_valid <= 1'b1;
            end else if (grant_mem && mem_we && mem_addr == buf_addr) begin
                buf_valid <= 1'b0;
            end
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Data port wins in IDLE; a buffered fetch hit is answered without leaving IDLE.
    always_comb begin
        state_next = state;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    grant_mem  = 1'b1;
                    state_next = mem_we ? WR_SETUP : RD_ADDR;
                end else if (if_req && !buf_hit) begin
                    grant_if   = 1'b1;
                    state_next = RD_ADDR;
                end
            end
            RD_ADDR:   state_next = RD_SAMPLE;
            RD_SAMPLE: state_next = IDLE;
            WR_SETUP:  state_next = WR_PULSE;
            WR_PULSE:  state_next = WR_HOLD;
            WR_HOLD:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            gnt_mem   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            if (grant_mem || grant_if) begin
                gnt_mem <= grant_mem;
                addr_q  <= grant_mem ? mem_addr : if_addr;
                wdata_q <= mem_wdata;
            end
            if (state == RD_SAMPLE) begin
                if (gnt_mem) begin
                    mem_rdata <= Ram2_data;
                    mem_ack   <= 1'b1;
                end else begin
                    if_rdata <= Ram2_data;
                    if_ack   <= 1'b1;
                end
            end
            if (state == WR_HOLD) begin
                mem_ack <= 1'b1;
            end
`ifdef RAM2_FETCH_BUF_EN
            if (state == IDLE && !mem_req && if_req && buf_hit) begin
                if_rdata <= buf_data;
                if_ack   <= 1'b1;
            end
`endif
        end
    end

    // Controls decode straight from state so an async reset releases the SRAM at once.
    assign busy         = (state != IDLE);
    assign Ram2_EN      = (state == IDLE);
    assign Ram2_OE      = !(state == RD_ADDR || state == RD_SAMPLE);
    assign Ram2_WE      = (state != WR_PULSE);
    assign Ram2_address = addr_q;
    assign bus_drive    = (state == WR_SETUP || state == WR_PULSE || state == WR_HOLD);
    assign Ram2_data    = bus_drive ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram2_ctrl.sv
// Directed bench for ram2_ctrl with an async SRAM model and an ack scoreboard.
// Fetch-buffer expectations follow `RAM2_FETCH_BUF_EN.
module tb_ram2_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        if_req = 1'b0;
    logic [17:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [17:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        Ram2_EN, Ram2_OE, Ram2_WE;
    logic [17:0] Ram2_address;
    wire  [15:0] Ram2_data;

    int total = 0;
    int bad = 0;

    ram2_ctrl #(.ADDR_W(18), .DATA_W(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy),
        .Ram2_EN(Ram2_EN), .Ram2_OE(Ram2_OE), .Ram2_WE(Ram2_WE),
        .Ram2_address(Ram2_address), .Ram2_data(Ram2_data)
    );

    always #5 Clk = ~Clk;

    // Asynchronous SRAM model: drives on read enable, captures mid write pulse.
    logic [15:0] sram [0:262143];
    assign Ram2_data = (!Ram2_EN && !Ram2_OE && Ram2_WE) ? sram[Ram2_address] : 16'hzzzz;

    int oe_low = 0, we_low = 0, bus_drv = 0, contention = 0;

    always @(negedge Clk) begin
        if (!Ram2_EN && !Ram2_WE) sram[Ram2_address] = Ram2_data;
        if (!Ram2_OE) oe_low++;
        if (!Ram2_WE) we_low++;
        if (Ram2_OE && Ram2_data !== 16'hzzzz) bus_drv++;
        if (!Ram2_OE && (!Ram2_WE || $isunknown(Ram2_data))) contention++;
    end

    typedef struct {
        bit          is_mem;
        bit          is_read;
        logic [15:0] data;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit is_mem, input bit we, input logic [17:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] exp_data, input int lat);
        exp_t e;
        if (is_mem) begin
            mem_req   = 1'b1;
            mem_we    = we;
            mem_addr  = addr;
            mem_wdata = wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = addr;
        end
        e.is_mem  = is_mem;
        e.is_read = !(is_mem && we);
        e.data    = exp_data;
        e.lat     = lat;
        sbq.push_back(e);
    endtask

    task automatic ackSeen(input bit is_mem, input int k);
        exp_t e;
        if (sbq.size() == 0) begin
            checkOutput("spurious_ack", {31'd0, is_mem}, 32'hffff_ffff);
            return;
        end
        e = sbq.pop_front();
        checkOutput("ack_port", {31'd0, is_mem}, {31'd0, e.is_mem});
        checkOutput("ack_latency", k, e.lat);
        if (e.is_read) checkOutput("ack_rdata", is_mem ? mem_rdata : if_rdata, e.data);
        if (is_mem) mem_req = 1'b0;
        else        if_req  = 1'b0;
    endtask

    task automatic runUntilDone(input int budget);
        int k = 0;
        while (sbq.size() > 0 && k < budget) begin
            @(posedge Clk);
            k++;
            @(negedge Clk);
            if (mem_ack) ackSeen(1'b1, k);
            if (if_ack)  ackSeen(1'b0, k);
        end
        if (sbq.size() > 0) begin
            checkOutput("ack_timeout", sbq.size(), 0);
            sbq.delete();
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int oe0, we0, bd0, ct0, acks;
        sram[18'h00010] = 16'h1234;
        sram[18'h00020] = 16'h5A5A;

        // Reset held for two cycles, then released.
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkOutput("rst_en", Ram2_EN, 1);
        checkOutput("rst_oe", Ram2_OE, 1);
        checkOutput("rst_we", Ram2_WE, 1);
        checkOutput("rst_addr", Ram2_address, 0);
        checkOutput("rst_bus_z", {31'd0, Ram2_data === 16'hzzzz}, 1);
        checkOutput("rst_acks", {30'd0, if_ack, mem_ack}, 0);
        checkOutput("rst_if_rdata", if_rdata, 0);
        checkOutput("rst_mem_rdata", mem_rdata, 0);
        checkOutput("rst_busy", busy, 0);
        Rst = 1'b0;
        @(negedge Clk);
        checkOutput("idle_busy", busy, 0);

        // Fetch read of 0x00010.
        oe0 = oe_low; we0 = we_low;
        applyStimulus(1'b0, 1'b0, 18'h00010, 16'h0, 16'h1234, 3);
        runUntilDone(12);
        checkOutput("fetch_oe_cycles", oe_low - oe0, 2);
        checkOutput("fetch_we_cycles", we_low - we0, 0);

        // Data write of 0xBEEF to 0x2ABCD.
        @(negedge Clk);
        we0 = we_low; bd0 = bus_drv;
        applyStimulus(1'b1, 1'b1, 18'h2ABCD, 16'hBEEF, 16'h0, 4);
        runUntilDone(12);
        checkOutput("write_we_cycles", we_low - we0, 1);
        checkOutput("write_bus_cycles", bus_drv - bd0, 3);
        checkOutput("write_sram", sram[18'h2ABCD], 16'hBEEF);
        checkOutput("write_mem_rdata_held", mem_rdata, 0);

        // Data read back.
        @(negedge Clk);
        applyStimulus(1'b1, 1'b0, 18'h2ABCD, 16'h0, 16'hBEEF, 3);
        runUntilDone(12);
        checkOutput("fetch_rdata_held", if_rdata, 16'h1234);

        // Simultaneous requests: data first, fetch granted in the data ack cycle.
        @(negedge Clk);
        ct0 = contention;
        applyStimulus(1'b1, 1'b0, 18'h2ABCD, 16'h0, 16'hBEEF, 3);
        applyStimulus(1'b0, 1'b0, 18'h00020, 16'h0, 16'h5A5A, 6);
        runUntilDone(16);
        checkOutput("simul_contention", contention - ct0, 0);

        // Refetch 0x00010 (buffer now holds 0x00020, so this is a full read).
        @(negedge Clk);
        oe0 = oe_low;
        applyStimulus(1'b0, 1'b0, 18'h00010, 16'h0, 16'h1234, 3);
        runUntilDone(12);
        checkOutput("refill_oe_cycles", oe_low - oe0, 2);

        // Repeat fetch of the same address.
        @(negedge Clk);
        oe0 = oe_low;
`ifdef RAM2_FETCH_BUF_EN
        applyStimulus(1'b0, 1'b0, 18'h00010, 16'h0, 16'h1234, 1);
        runUntilDone(12);
        checkOutput("hit_oe_cycles", oe_low - oe0, 0);
        checkOutput("hit_busy", busy, 0);
`else
        applyStimulus(1'b0, 1'b0, 18'h00010, 16'h0, 16'h1234, 3);
        runUntilDone(12);
        checkOutput("repeat_oe_cycles", oe_low - oe0, 2);
`endif

        // Data write to the fetched address, then fetch it again from the SRAM.
        @(negedge Clk);
        applyStimulus(1'b1, 1'b1, 18'h00010, 16'h7777, 16'h0, 4);
        runUntilDone(12);
        @(negedge Clk);
        oe0 = oe_low;
        applyStimulus(1'b0, 1'b0, 18'h00010, 16'h0, 16'h7777, 3);
        runUntilDone(12);
        checkOutput("inval_oe_cycles", oe_low - oe0, 2);

        // Reset asserted during the write pulse.
        @(negedge Clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00030; mem_wdata = 16'h1111;
        @(posedge Clk);
        @(posedge Clk);
        #2;
        checkOutput("rstw_we_low", Ram2_WE, 0);
        Rst = 1'b1;
        mem_req = 1'b0;
        #1;
        checkOutput("rstw_we_high", Ram2_WE, 1);
        checkOutput("rstw_en_high", Ram2_EN, 1);
        checkOutput("rstw_bus_z", {31'd0, Ram2_data === 16'hzzzz}, 1);
        checkOutput("rstw_busy", busy, 0);
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (mem_ack) acks++;
            if (i == 1) Rst = 1'b0;
        end
        checkOutput("rstw_no_ack", acks, 0);
        checkOutput("rstw_not_written", {31'd0, sram[18'h00030] === 16'h1111}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
